// File: rtl/seg_scan_ctrl.sv
// Scan controller for a two-digit 7-segment display: drives the segment mux
// select, registers the selected pattern and generates blanked digit enables.
module seg_scan_ctrl #(
  parameter int DIV            = 4,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_in,
  output logic       sel,
  output logic [6:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);

  localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;
  // Flipping one bit of the "both off" pattern turns exactly one digit on.
  localparam logic [1:0] DIG_A_ON = DIG_OFF ^ 2'b10;
  localparam logic [1:0] DIG_B_ON = DIG_OFF ^ 2'b01;

  typedef enum logic [1:0] {
    GAP_BA,
    SHOW_A,
    GAP_AB,
    SHOW_B
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [6:0]    seg_q,   seg_d;
  logic [1:0]    dig_q,   dig_d;
  logic          phase_last;

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves a latch behind.
    state_d    = state_q;
    cnt_d      = cnt_q;
    seg_d      = SEG_OFF;
    dig_d      = DIG_OFF;
    phase_last = 1'b0;

    if (en) begin
      if (state_q == SHOW_A || state_q == SHOW_B) begin
        phase_last = (cnt_q == SHOW_LAST);
      end else begin
        phase_last = (cnt_q == GAP_LAST);
      end

      if (phase_last) begin
        cnt_d = '0;
        unique case (state_q)
          GAP_BA:  state_d = SHOW_A;
          SHOW_A:  state_d = GAP_AB;
          GAP_AB:  state_d = SHOW_B;
          default: state_d = GAP_BA;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      // Only SHOW states sample the mux; gaps always present a blank digit.
      if (state_q == SHOW_A) begin
        seg_d = seg_in;
        dig_d = DIG_A_ON;
      end else if (state_q == SHOW_B) begin
        seg_d = seg_in;
        dig_d = DIG_B_ON;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= GAP_BA;
      cnt_q   <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  // sel leads the displayed digit by a whole gap, giving the mux time to settle.
  assign sel        = (state_q == GAP_BA) || (state_q == SHOW_A);
  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_tick = (state_q == SHOW_B) && (cnt_q == SHOW_LAST) && en;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl: two configurations share one
// stimulus stream and are compared against a frame-position reference model.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] seg_in0, seg_in1;
  logic       sel0, sel1;
  logic [6:0] seg_out0, seg_out1;
  logic [1:0] dig_en0, dig_en1;
  logic       tick0, tick1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIV(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in0),
    .sel(sel0), .seg_out(seg_out0), .dig_en(dig_en0), .frame_tick(tick0)
  );

  seg_scan_ctrl #(
    .DIV(1), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in1),
    .sel(sel1), .seg_out(seg_out1), .dig_en(dig_en1), .frame_tick(tick1)
  );

  typedef struct packed {
    logic       sel;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       tick;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  int         div_c   [2] = '{4, 1};
  int         blank_c [2] = '{2, 1};
  logic [6:0] seg_off [2] = '{7'h7F, 7'h00};
  logic [1:0] dig_off [2] = '{2'b11, 2'b00};
  logic [6:0] pat_a   [2] = '{7'h06, 7'h3F};
  logic [6:0] pat_b   [2] = '{7'h5B, 7'h4F};

  // Reference state: position within the frame plus the registered outputs.
  int         pos   [2];
  logic [6:0] m_seg [2];
  logic [1:0] m_dig [2];

  function automatic int period(input int k);
    return 2 * (div_c[k] + blank_c[k]);
  endfunction

  // 0 = gap before A, 1 = show A, 2 = gap before B, 3 = show B
  function automatic int phase(input int k, input int p);
    if (p < blank_c[k])                     return 0;
    if (p < blank_c[k] + div_c[k])          return 1;
    if (p < 2 * blank_c[k] + div_c[k])      return 2;
    return 3;
  endfunction

  task automatic model_edge(input int k, input logic [6:0] s);
    int ph;
    if (rst) begin
      pos[k]   = 0;
      m_seg[k] = seg_off[k];
      m_dig[k] = dig_off[k];
    end else if (en) begin
      ph = phase(k, pos[k]);
      if (ph == 1) begin
        m_seg[k] = s;
        m_dig[k] = dig_off[k] ^ 2'b10;
      end else if (ph == 3) begin
        m_seg[k] = s;
        m_dig[k] = dig_off[k] ^ 2'b01;
      end else begin
        m_seg[k] = seg_off[k];
        m_dig[k] = dig_off[k];
      end
      pos[k] = (pos[k] + 1) % period(k);
    end else begin
      m_seg[k] = seg_off[k];
      m_dig[k] = dig_off[k];
    end
  endtask

  function automatic exp_t expect_now(input int k);
    exp_t e;
    e.sel  = (phase(k, pos[k]) <= 1);
    e.seg  = m_seg[k];
    e.dig  = m_dig[k];
    e.tick = (pos[k] == period(k) - 1) && en;
    return e;
  endfunction

  function automatic logic [6:0] pick_seg(input int k, input bit follow);
    int ph;
    ph = phase(k, pos[k]);
    if (!follow || ph == 0 || ph == 2) return 7'($urandom);
    return (ph == 1) ? pat_a[k] : pat_b[k];
  endfunction

  // One clock: update the model with the inputs just sampled, then drive the
  // inputs for the next edge and queue what the outputs must show meanwhile.
  task automatic step(input bit r, input bit e, input bit follow);
    @(posedge clk);
    model_edge(0, seg_in0);
    model_edge(1, seg_in1);
    #1;
    rst     = r;
    en      = e;
    seg_in0 = pick_seg(0, follow);
    seg_in1 = pick_seg(1, follow);
    q0.push_back(expect_now(0));
    q1.push_back(expect_now(1));
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : driver
    rst     = 1'b1;
    en      = 1'b1;
    seg_in0 = 7'h00;
    seg_in1 = 7'h00;
    pos     = '{0, 0};
    m_seg   = '{7'h7F, 7'h00};
    m_dig   = '{2'b11, 2'b00};

    repeat (2)  step(1'b1, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (4)  step(1'b0, 1'b1, 1'b1);
    repeat (5)  step(1'b0, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) != 0), i[9]);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    check("queue0_drained", 8'(q0.size()), 8'd0);
    check("queue1_drained", 8'(q1.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("d0_sel",  8'(sel0),     8'(e.sel));
        check("d0_seg",  8'(seg_out0), 8'(e.seg));
        check("d0_dig",  8'(dig_en0),  8'(e.dig));
        check("d0_tick", 8'(tick0),    8'(e.tick));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d1_sel",  8'(sel1),     8'(e.sel));
        check("d1_seg",  8'(seg_out1), 8'(e.seg));
        check("d1_dig",  8'(dig_en1),  8'(e.dig));
        check("d1_tick", 8'(tick1),    8'(e.tick));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
